// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared types and defaults for the systolic array input stage
package systolic_feeder_pkg;
  localparam int SYS_ARRAY_SIZE = 4;
  localparam int DATA_W = 16;
  localparam int FEED_FLUSH_LEN = 2 * SYS_ARRAY_SIZE;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} feed_state_e;
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: beat handshake in, skewed lanes and tile control out
interface systolic_feeder_if #(parameter int N = systolic_feeder_pkg::SYS_ARRAY_SIZE);
  import systolic_feeder_pkg::*;
  logic in_valid_i;
  logic in_ready_o;
  logic in_last_i;
  data_t in_a_i [N];
  data_t in_b_i [N];
  data_t a_o [N];
  data_t b_o [N];
  logic last_o;
  logic ctrl_o;
  logic busy_o;
  modport master (
    output in_valid_i, in_last_i, in_a_i, in_b_i,
    input in_ready_o, a_o, b_o, last_o, ctrl_o, busy_o
  );
  modport slave (
    input in_valid_i, in_last_i, in_a_i, in_b_i,
    output in_ready_o, a_o, b_o, last_o, ctrl_o, busy_o
  );
endinterface

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage shift register with asynchronous active-low clear
module skew_line #(
  parameter int DEPTH = 1,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  T     d_i,
  output T     q_o
);
  T r [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r <= '{default: '0};
    else begin
      r[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) r[k] <= r[k-1];
    end
  end
  assign q_o = r[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B beats into the array and sequences flush, last and drain per tile
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N = SYS_ARRAY_SIZE,
  parameter int FLUSH_LEN = FEED_FLUSH_LEN
) (
  input logic clk_i,
  input logic rst_ni,
  systolic_feeder_if.slave bus
);
  localparam int FW = $clog2(FLUSH_LEN);
  localparam int DW = $clog2(N) + 1;
  feed_state_e state, state_nxt;
  logic [FW-1:0] fcnt;
  logic [DW-1:0] dcnt;
  logic acc, flush_done, drain_done;
  assign bus.in_ready_o = state == IDLE || state == FEED;
  assign bus.busy_o = state == FLUSH || state == DRAIN;
  assign bus.ctrl_o = state == DRAIN;
  assign bus.last_o = flush_done;
  assign acc = bus.in_valid_i && bus.in_ready_o;
  assign flush_done = state == FLUSH && fcnt == FW'(FLUSH_LEN - 1);
  assign drain_done = state == DRAIN && dcnt == DW'(N - 1);
  always_comb begin
    state_nxt = acc ? (bus.in_last_i ? FLUSH : FEED) :
                flush_done ? DRAIN :
                drain_done ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      fcnt <= '0;
      dcnt <= '0;
    end else begin
      state <= state_nxt;
      fcnt <= (state == FLUSH && !flush_done) ? fcnt + 1'b1 : '0;
      dcnt <= (state == DRAIN && !drain_done) ? dcnt + 1'b1 : '0;
    end
  end
  // Cycles without an accepted beat push zeros, so every lane sees the same bubble
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .T(data_t)) u_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(acc ? bus.in_a_i[i] : '0), .q_o(bus.a_o[i])
    );
    skew_line #(.DEPTH(i + 1), .T(data_t)) u_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(acc ? bus.in_b_i[i] : '0), .q_o(bus.b_o[i])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed and random tiles checked against a cycle-timeline reference model
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;
  localparam int N = 4;
  localparam int F = 8;
  localparam int MAXC = 4096;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  systolic_feeder_if #(.N(N)) bus ();
  systolic_feeder #(.N(N), .FLUSH_LEN(F)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int last_cyc = -1000;
  data_t ha [MAXC][N];
  data_t hb [MAXC][N];
  function automatic bit m_busy();
    int d = cyc - last_cyc;
    return d >= 1 && d <= F + N;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic check_cycle();
    int d = cyc - last_cyc;
    chk("in_ready", 32'(bus.in_ready_o), 32'(!m_busy()));
    chk("busy", 32'(bus.busy_o), 32'(m_busy()));
    chk("last", 32'(bus.last_o), 32'(d == F));
    chk("ctrl", 32'(bus.ctrl_o), 32'(d > F && d <= F + N));
    for (int i = 0; i < N; i++) begin
      int k = cyc - i - 1;
      chk($sformatf("a[%0d]", i), 32'(bus.a_o[i]), 32'(k >= rst_cyc ? ha[k][i] : data_t'(0)));
      chk($sformatf("b[%0d]", i), 32'(bus.b_o[i]), 32'(k >= rst_cyc ? hb[k][i] : data_t'(0)));
    end
  endtask
  task automatic tick(input bit v, input bit l, input data_t a [N], input data_t b [N]);
    bit acc;
    bus.in_valid_i = v;
    bus.in_last_i = l;
    bus.in_a_i = a;
    bus.in_b_i = b;
    check_cycle();
    acc = v && !m_busy();
    for (int i = 0; i < N; i++) begin
      ha[cyc][i] = acc ? a[i] : '0;
      hb[cyc][i] = acc ? b[i] : '0;
    end
    if (acc && l) last_cyc = cyc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic rtick(input bit v, input bit l);
    data_t a [N];
    data_t b [N];
    for (int i = 0; i < N; i++) begin
      a[i] = data_t'($urandom);
      b[i] = data_t'($urandom);
    end
    tick(v, l, a, b);
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) rtick(1'b0, 1'b0);
  endtask
  task automatic do_reset();
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_a", 32'(bus.a_o[i]), 32'(0));
      chk("rst_b", 32'(bus.b_o[i]), 32'(0));
    end
    chk("rst_last", 32'(bus.last_o), 32'(0));
    chk("rst_ctrl", 32'(bus.ctrl_o), 32'(0));
    chk("rst_busy", 32'(bus.busy_o), 32'(0));
    chk("rst_ready", 32'(bus.in_ready_o), 32'(1));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    rst_cyc = cyc;
    last_cyc = -1000;
  endtask
  initial begin
    data_t v1234 [N];
    int busy_cnt;
    for (int i = 0; i < N; i++) v1234[i] = data_t'(i + 1);
    bus.in_valid_i = 1'b0;
    bus.in_last_i = 1'b0;
    bus.in_a_i = '{default: '0};
    bus.in_b_i = '{default: '0};
    @(negedge clk);
    do_reset();
    // single-beat tile: skew alignment and flush/drain timeline
    tick(1'b1, 1'b1, v1234, v1234);
    idle(14);
    // bubble insertion inside a 3-beat tile
    rtick(1'b1, 1'b0);
    idle(2);
    rtick(1'b1, 1'b0);
    rtick(1'b1, 1'b1);
    idle(14);
    // valid held high through FLUSH and DRAIN, next tile starts back-to-back
    rtick(1'b1, 1'b1);
    busy_cnt = 0;
    for (int j = 0; j < 14; j++) begin
      if (bus.busy_o) busy_cnt++;
      rtick(1'b1, 1'b0);
    end
    chk("busy_len", 32'(busy_cnt), 32'(F + N));
    rtick(1'b1, 1'b1);
    idle(14);
    // reset mid-FEED with data in flight, then the reference single-beat tile again
    rtick(1'b1, 1'b0);
    rtick(1'b1, 1'b0);
    do_reset();
    tick(1'b1, 1'b1, v1234, v1234);
    idle(14);
    // randomized traffic
    for (int j = 0; j < 500; j++) rtick(($urandom % 4) != 0, ($urandom % 5) == 0);
    idle(14);
    do_reset();
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
